// File: rtl/pdm_mic.sv
// pdm_mic: PDM microphone receiver on the iomem peripheral bus.
//
// Generates the microphone bit clock and decimates the 1-bit PDM stream into
// signed 16-bit PCM samples with a ones-count boxcar filter. Samples go into
// a FIFO that the CPU drains through memory-mapped registers.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   iomem_valid         bus request (address decode done outside)
//   iomem_wstrb[3:0]    byte write strobes, all zero = read
//   iomem_addr[31:0]    only [3:2] decoded: 0 CTRL, 1 STATUS, 2 DATA, 3 none
//   iomem_wdata[31:0]   write data
//   iomem_rdata[31:0]   registered read data, zero when iomem_ready is low
//   iomem_ready         single-cycle acknowledge
//   mic_clk             PDM bit clock to the microphone
//   mic_data            PDM data from the microphone (asynchronous)
//   irq                 FIFO level interrupt
//
// Optional feature macro: PDM_MIC_IRQ_EN (enables irq and the CTRL irq_en bit).
module pdm_mic #(
  parameter int CLK_DIV    = 8,
  parameter int DECIM      = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        iomem_ready,
  output logic        mic_clk,
  input  logic        mic_data,
  output logic        irq
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LOG_D = $clog2(DECIM);
  localparam int CNT_W = LOG_D + 1;
  localparam int SHIFT = 15 - LOG_D;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DATA   = 2'd2,
    REG_NONE   = 2'd3
  } reg_sel_e;

  reg_sel_e         sel;
  logic             access, wr, rd, ctrl_wr, clr;
  logic             ctrl_en, irq_en_r;
  logic [31:0]      rd_val;

  logic             sync1, sync2;
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap, fall;
  logic [CNT_W-1:0] ones, bit_cnt;
  logic             push;
  logic [31:0]      wide;
  logic [15:0]      sample;

  logic [15:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             ovf, empty, full, pop, do_push, do_pop;

  // ---------------- bus decode ----------------
  assign sel     = reg_sel_e'(iomem_addr[3:2]);
  // The access (read capture and all side effects) happens on the edge that
  // raises iomem_ready, so its effects are visible during the ready cycle.
  assign access  = iomem_valid && !iomem_ready;
  assign wr      = access && (iomem_wstrb != 4'b0000);
  assign rd      = access && (iomem_wstrb == 4'b0000);
  assign ctrl_wr = wr && (sel == REG_CTRL);
  assign clr     = ctrl_wr && iomem_wdata[1];

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign pop     = rd && (sel == REG_DATA) && !empty;
  assign do_pop  = pop && !clr;
  assign do_push = push && !clr && (!full || do_pop);

  always_comb begin
    rd_val = '0;
    unique case (sel)
      REG_CTRL:   rd_val = {29'b0, irq_en_r, 1'b0, ctrl_en};
      REG_STATUS: rd_val = {21'b0, ovf, full, empty, 8'(count)};
      REG_DATA:   rd_val = empty ? 32'h0 : {16'h0, mem[rptr]};
      REG_NONE:   rd_val = '0;
    endcase
  end

  // ---------------- PDM front end ----------------
  assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall     = div_wrap && mic_clk;
  // A word completes one cycle after its last bit was counted.
  assign push     = ctrl_en && (bit_cnt == CNT_W'(DECIM));

  always_comb begin
    wide   = ((32'(ones) << 1) - 32'(DECIM)) << SHIFT;
    sample = (ones == CNT_W'(DECIM)) ? 16'h7FFF : wide[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      div_cnt <= '0;
      mic_clk <= 1'b0;
      ones    <= '0;
      bit_cnt <= '0;
    end else begin
      sync1 <= mic_data;
      sync2 <= sync1;
      if (!ctrl_en) begin
        div_cnt <= '0;
        mic_clk <= 1'b0;
        ones    <= '0;
        bit_cnt <= '0;
      end else begin
        if (div_wrap) begin
          div_cnt <= '0;
          mic_clk <= ~mic_clk;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (push) begin
          ones    <= '0;
          bit_cnt <= '0;
        end else if (fall) begin
          bit_cnt <= bit_cnt + 1'b1;
          ones    <= ones + CNT_W'(sync2);
        end
      end
    end
  end

  // ---------------- bus registers and FIFO control ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      ctrl_en     <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      ovf         <= 1'b0;
    end else begin
      iomem_ready <= access;
      iomem_rdata <= access ? rd_val : '0;
      if (ctrl_wr) ctrl_en <= iomem_wdata[0];
      if (clr) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end else begin
        if (do_push) wptr <= wptr + 1'b1;
        if (do_pop)  rptr <= rptr + 1'b1;
        if (do_push && !do_pop)      count <= count + 1'b1;
        else if (!do_push && do_pop) count <= count - 1'b1;
        if (push && !do_push) ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= sample;
  end

  // ---------------- interrupt ----------------
`ifdef PDM_MIC_IRQ_EN
  logic irq_r;
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_r <= iomem_wdata[2];
      irq_r <= irq_en_r && ((count >= (AW+1)'(FIFO_DEPTH / 2)) || ovf);
    end
  end
  assign irq = irq_r;
`else
  assign irq_en_r = 1'b0;
  assign irq      = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{iomem_addr[31:4], iomem_addr[1:0], iomem_wdata[31:2], wide[31:16]};

endmodule
